// File: rtl/async_pipe_launch_ctrl.sv
// Launch sequencer for the async Booth-multiplier pipeline: two-phase request
// launch, synchronized two-phase ack counting, in-flight bound, launch spacing
// and completion watchdog.
module async_pipe_launch_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CW          = 3,
  parameter int unsigned MIN_GAP     = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  output logic          req_out,
  input  logic          ack_in,
  output logic          done_valid,
  output logic [CW-1:0] inflight,
  output logic          long_sel,
  output logic          busy,
  output logic          timeout_err,
  input  logic          err_clr
);

  localparam int unsigned GW        = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack_q;
  logic                   r_req;
  logic [CW-1:0]          r_inflight;
  logic [GW-1:0]          r_gap;
  logic [TW-1:0]          r_wdog;
  logic                   r_done;
  logic                   r_err;
  logic                   r_busy;
  logic                   r_long;

  logic                   w_ack_s;
  logic                   w_ack_s_nxt;
  logic                   w_ack_ev;
  logic                   w_done_ev;
  logic                   w_start_ready;
  logic                   w_fire;
  logic                   w_req_nxt;
  logic [CW-1:0]          w_inflight_nxt;
  logic [GW-1:0]          w_gap_nxt;
  logic [TW-1:0]          w_wdog_nxt;

  assign w_ack_s     = r_sync[SYNC_STAGES-1];
  assign w_ack_s_nxt = r_sync[SYNC_STAGES-2];
  assign w_ack_ev    = w_ack_s ^ r_ack_q;
  // An ack edge with nothing in flight is spurious and ignored.
  assign w_done_ev   = w_ack_ev && (r_inflight != '0);

  // Launch is allowed only outside ERR, below the in-flight bound and after the spacing gap.
  always_comb begin
    w_start_ready = 1'b0;
    if ((r_state == S_IDLE || r_state == S_RUN) && (r_inflight < DEPTH_C) && (r_gap == '0)) begin
      w_start_ready = 1'b1;
    end
  end

  assign w_fire = start_valid && w_start_ready;

  // Next-state, counter, gap and watchdog updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req ^ w_fire;
    w_inflight_nxt = r_inflight;
    w_gap_nxt      = r_gap;
    w_wdog_nxt     = r_wdog;

    case ({w_fire, w_done_ev})
      2'b10:   w_inflight_nxt = r_inflight + CW'(1);
      2'b01:   w_inflight_nxt = r_inflight - CW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase

    if (w_fire) begin
      w_gap_nxt = GAP_LOAD;
    end else if (r_gap != '0) begin
      w_gap_nxt = r_gap - GW'(1);
    end

    if ((r_inflight == '0) || w_ack_ev) begin
      w_wdog_nxt = '0;
    end else if ((r_state == S_RUN) && (r_wdog < TIMEOUT_C)) begin
      w_wdog_nxt = r_wdog + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((w_inflight_nxt == '0) && !w_fire) begin
          w_state_nxt = S_IDLE;
        end else if (w_wdog_nxt == TIMEOUT_C) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          w_state_nxt = (w_inflight_nxt == '0) ? S_IDLE : S_RUN;
          w_wdog_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Ack synchronizer, state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync     <= '0;
      r_ack_q    <= 1'b0;
      r_req      <= 1'b0;
      r_inflight <= '0;
      r_gap      <= '0;
      r_wdog     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_long     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], ack_in};
      r_ack_q    <= w_ack_s;
      r_req      <= w_req_nxt;
      r_inflight <= w_inflight_nxt;
      r_gap      <= w_gap_nxt;
      r_wdog     <= w_wdog_nxt;
      r_done     <= w_done_ev;
      r_err      <= (w_state_nxt == S_ERR);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_long     <= ~(w_req_nxt ^ w_ack_s_nxt);
    end
  end

  assign start_ready = w_start_ready;
  assign req_out     = r_req;
  assign done_valid  = r_done;
  assign inflight    = r_inflight;
  assign long_sel    = r_long;
  assign busy        = r_busy;
  assign timeout_err = r_err;

endmodule
